// File: rtl/dline_responder.sv
// dline_responder: fully-associative write-back line buffer answering ufp word requests over a line-wide dfp port.
// Optional DLINE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module dline_responder #(
    parameter int NUM_LINES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ufp_addr,
    input  logic [3:0]   ufp_rmask,
    input  logic [3:0]   ufp_wmask,
    input  logic [31:0]  ufp_wdata,
    output logic [31:0]  ufp_rdata,
    output logic         ufp_resp,
    output logic [31:0]  dfp_addr,
    output logic         dfp_read,
    output logic         dfp_write,
    output logic [255:0] dfp_wdata,
    input  logic [255:0] dfp_rdata,
    input  logic         dfp_resp
`ifdef DLINE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int IW = $clog2(NUM_LINES);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FETCH, FILL} state_t;

    state_t               state_q, state_d;
    logic [31:2]          addr_q;
    logic [3:0]           rmask_q, wmask_q;
    logic [31:0]          wdata_q;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [26:0]          tag_q [NUM_LINES];
    logic [255:0]         data_q [NUM_LINES];
    logic [IW-1:0]        rr_q, vic_q, vic, hit_idx;
    logic                 repl_q, refill_q, hit, found, is_wr;
    logic [31:0]          hit_word, rmask32, wmask32;
    logic                 unused;

    assign unused   = ^ufp_addr[1:0];
    assign is_wr    = |wmask_q;
    assign rmask32  = {{8{rmask_q[3]}}, {8{rmask_q[2]}}, {8{rmask_q[1]}}, {8{rmask_q[0]}}};
    assign wmask32  = {{8{wmask_q[3]}}, {8{wmask_q[2]}}, {8{wmask_q[1]}}, {8{wmask_q[0]}}};
    assign hit_word = data_q[hit_idx][{addr_q[4:2], 5'b0} +: 32];

    // Tag match plus victim choice: lowest invalid entry, else round-robin pointer.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        found   = 1'b0;
        vic     = rr_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && tag_q[i] == addr_q[31:5]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i] && !found) begin
                found = 1'b1;
                vic   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_addr  = '0;
        dfp_wdata = '0;
        if (!rst) begin
            case (state_q)
                IDLE: state_d = (|ufp_rmask || |ufp_wmask) ? LOOKUP : IDLE;
                LOOKUP: begin
                    ufp_resp  = hit;
                    ufp_rdata = (hit && !is_wr) ? (hit_word & rmask32) : '0;
                    state_d   = hit ? IDLE : (valid_q[vic] && dirty_q[vic]) ? WRITEBACK : FETCH;
                end
                WRITEBACK: begin
                    dfp_write = 1'b1;
                    dfp_addr  = {tag_q[vic_q], 5'b0};
                    dfp_wdata = data_q[vic_q];
                    state_d   = dfp_resp ? FETCH : WRITEBACK;
                end
                FETCH: begin
                    dfp_read = 1'b1;
                    dfp_addr = {addr_q[31:5], 5'b0};
                    state_d  = dfp_resp ? FILL : FETCH;
                end
                // Settle cycle keeps fill-to-response latency at two cycles.
                FILL: state_d = LOOKUP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            rr_q     <= '0;
            refill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            refill_q <= state_q == FILL;
            if (state_q == LOOKUP && hit && is_wr) dirty_q[hit_idx] <= 1'b1;
            if (state_q == WRITEBACK && dfp_resp) dirty_q[vic_q] <= 1'b0;
            if (state_q == FETCH && dfp_resp) begin
                valid_q[vic_q] <= 1'b1;
                dirty_q[vic_q] <= 1'b0;
                rr_q           <= repl_q ? rr_q + 1'b1 : rr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            addr_q  <= ufp_addr[31:2];
            rmask_q <= ufp_rmask;
            wmask_q <= ufp_wmask;
            wdata_q <= ufp_wdata;
        end
        if (state_q == LOOKUP && !hit) begin
            vic_q  <= vic;
            repl_q <= valid_q[vic];
        end
        if (state_q == LOOKUP && hit && is_wr)
            data_q[hit_idx][{addr_q[4:2], 5'b0} +: 32] <= (hit_word & ~wmask32) | (wdata_q & wmask32);
        if (state_q == FETCH && dfp_resp && !rst) begin
            data_q[vic_q] <= dfp_rdata;
            tag_q[vic_q]  <= addr_q[31:5];
        end
    end

`ifdef DLINE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit && !refill_q && hit_count != '1) hit_count <= hit_count + 1'b1;
            if (!hit && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dline_responder.sv
// tb_dline_responder: directed bench with an address-level cache/memory model and a per-cycle compare process.
module tb_dline_responder;
    localparam int NL = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ufp_addr, ufp_wdata, ufp_rdata, dfp_addr;
    logic [3:0]   ufp_rmask, ufp_wmask;
    logic         ufp_resp, dfp_read, dfp_write, dfp_resp;
    logic [255:0] dfp_wdata, dfp_rdata, mem_rdata;
    logic         mem_resp, stray_resp;
`ifdef DLINE_PERF_CNT_EN
    logic [31:0]  hit_count, miss_count;
`endif

    assign dfp_resp  = mem_resp | stray_resp;
    assign dfp_rdata = stray_resp ? '1 : mem_rdata;

    dline_responder #(.NUM_LINES(NL)) dut (
        .clk(clk), .rst(rst),
        .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
        .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
        .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
`ifdef DLINE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Backing memory (what dfp holds) and architectural memory (what a flat memory would hold).
    logic [255:0] mem [logic [31:0]];
    logic [255:0] arch [logic [31:0]];

    function automatic logic [255:0] gen_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(w * 4) + 32'h5000_0000;
        return l;
    endfunction
    function automatic logic [255:0] get_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : gen_line(a);
    endfunction
    function automatic logic [255:0] get_arch(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : gen_line(a);
    endfunction
    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    // Residency model: which line sits in which slot, dirtiness, replacement pointer.
    logic [31:0]  s_tag [NL];
    bit           s_v [NL], s_d [NL];
    int           rr = 0, m_hit = 0, m_miss = 0;
    bit           exp_hit, exp_wb;
    logic [31:0]  exp_wb_addr, exp_fetch_addr, exp_rdata;
    logic [255:0] exp_wb_data;

    task automatic model_access(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd);
        logic [31:0]  line;
        logic [255:0] cur;
        int           w, idx;
        line = {a[31:5], 5'b0};
        w = int'(a[4:2]);
        idx = -1;
        exp_hit = 0;
        for (int i = 0; i < NL; i++) if (s_v[i] && s_tag[i] == line) begin exp_hit = 1; idx = i; end
        exp_wb = 0;
        exp_fetch_addr = line;
        if (exp_hit) m_hit++;
        else begin
            m_miss++;
            for (int i = 0; i < NL; i++) if (!s_v[i] && idx < 0) idx = i;
            if (idx < 0) begin idx = rr; rr = (rr + 1) % NL; end
            exp_wb = s_v[idx] && s_d[idx];
            exp_wb_addr = s_tag[idx];
            exp_wb_data = get_arch(s_tag[idx]);
            s_v[idx] = 1; s_d[idx] = 0; s_tag[idx] = line;
        end
        cur = get_arch(line);
        if (wm != 0) begin
            cur[w*32 +: 32] = (cur[w*32 +: 32] & ~expand(wm)) | (wd & expand(wm));
            arch[line] = cur;
            s_d[idx] = 1;
            exp_rdata = 0;
        end else exp_rdata = cur[w*32 +: 32] & expand(rm);
    endtask

    // Memory responder: answers two cycles after it sees a request, records activity.
    bit           mem_en;
    int           n_rd = 0, n_wr = 0, rd_start, rd_resp, wr_start, wr_resp;
    logic [31:0]  last_rd_addr, last_wr_addr;
    logic [255:0] last_wr_data;
    initial begin
        logic [31:0] a;
        bit          is_wr;
        mem_resp = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en && (dfp_read || dfp_write)) begin
                is_wr = dfp_write;
                a = dfp_addr;
                if (is_wr) begin n_wr++; wr_start = cyc; last_wr_addr = a; last_wr_data = dfp_wdata; end
                else begin n_rd++; rd_start = cyc; last_rd_addr = a; end
                repeat (2) @(posedge clk);
                #1;
                mem_resp = 1;
                mem_rdata = is_wr ? '0 : get_mem(a);
                if (is_wr) begin mem[a] = last_wr_data; wr_resp = cyc; end
                else rd_resp = cyc;
                @(posedge clk);
                #1;
                mem_resp = 0;
                mem_rdata = '0;
            end
        end
    end

    // Per-cycle compare against the model's expectation for the request in flight.
    bit   chk_en = 0, busy = 0;
    logic prev_resp = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            if (!busy)
                chk(!ufp_resp && !dfp_read && !dfp_write && ufp_rdata == 0 && dfp_addr == 0 && dfp_wdata == 0,
                    "idle_outputs", {ufp_resp, dfp_read, dfp_write, ufp_rdata, dfp_addr}, 0);
            else begin
                chk(!(dfp_read && dfp_write), "rd_wr_exclusive", {dfp_read, dfp_write}, 0);
                chk(!(ufp_resp && prev_resp), "resp_back_to_back", {prev_resp, ufp_resp}, 0);
                chk(ufp_resp ? ufp_rdata == exp_rdata : ufp_rdata == 0, "ufp_rdata", ufp_rdata, ufp_resp ? exp_rdata : 0);
                if (dfp_write) begin
                    chk(exp_wb, "unexpected_wb", 1, exp_wb);
                    chk(dfp_addr == exp_wb_addr, "wb_addr", dfp_addr, exp_wb_addr);
                    chk(dfp_wdata == exp_wb_data, "wb_data", dfp_wdata, exp_wb_data);
                end
                if (dfp_read) begin
                    chk(!exp_hit, "fetch_on_hit", 1, 0);
                    chk(dfp_addr == exp_fetch_addr, "fetch_addr", dfp_addr, exp_fetch_addr);
                end
            end
        end
        prev_resp <= ufp_resp;
    end

    task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                       output logic [31:0] got);
        int n, rc, rd0, wr0;
        model_access(a, rm, wm, wd);
        rd0 = n_rd;
        wr0 = n_wr;
        @(posedge clk);
        #1;
        ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
        busy = 1;
        rc = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!ufp_resp && n < 300);
        got = ufp_rdata;
        chk(ufp_resp, "resp_timeout", ufp_resp, 1);
        if (exp_hit) begin
            chk(cyc == rc + 1, "hit_latency", cyc - rc, 1);
            chk(n_rd == rd0 && n_wr == wr0, "hit_no_dfp", n_rd - rd0 + n_wr - wr0, 0);
        end else begin
            chk(n_rd == rd0 + 1, "fetch_count", n_rd - rd0, 1);
            chk(n_wr == wr0 + int'(exp_wb), "wb_count", n_wr - wr0, exp_wb);
            if (exp_wb) begin
                chk(wr_start == rc + 2, "wb_start", wr_start - rc, 2);
                chk(rd_start == wr_resp + 1, "fetch_after_wb", rd_start - wr_resp, 1);
            end else chk(rd_start == rc + 2, "fetch_start", rd_start - rc, 2);
            chk(cyc == rd_resp + 2, "fill_latency", cyc - rd_resp, 2);
        end
        @(posedge clk);
        #1;
        ufp_rmask = 0; ufp_wmask = 0;
        busy = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  got;
        logic [255:0] l;
        int           n;
        rst = 1; ufp_addr = 0; ufp_rmask = 0; ufp_wmask = 0; ufp_wdata = 0;
        mem_en = 1; stray_resp = 0;
        l = gen_line(32'h100);
        l[31:0] = 32'hDEAD_BEEF;
        l[63:32] = 32'hCAFE_F00D;
        mem[32'h100] = l;
        arch[32'h100] = l;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(ufp_resp == 0 && ufp_rdata == 0, "reset_ufp", {ufp_resp, ufp_rdata}, 0);
        chk(dfp_read == 0 && dfp_write == 0 && dfp_addr == 0, "reset_dfp", {dfp_read, dfp_write, dfp_addr}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;

        req(32'h100, 4'hF, 4'h0, 0, got);
        chk(got == 32'hDEAD_BEEF, "cold_read", got, 32'hDEAD_BEEF);
        chk(last_rd_addr == 32'h100, "cold_fetch_addr", last_rd_addr, 32'h100);
        req(32'h104, 4'hF, 4'h0, 0, got);
        chk(got == 32'hCAFE_F00D, "hit_read", got, 32'hCAFE_F00D);
        req(32'h104, 4'b0101, 4'h0, 0, got);
        chk(got == 32'h00FE_000D, "masked_read", got, 32'h00FE_000D);
        req(32'h100, 4'h0, 4'b0010, 32'h0000_AB00, got);
        chk(got == 0, "write_rdata_zero", got, 0);
        req(32'h100, 4'hF, 4'h0, 0, got);
        chk(got == 32'hDEAD_ABEF, "byte_merge", got, 32'hDEAD_ABEF);

        req(32'h200, 4'hF, 4'h0, 0, got);
        req(32'h300, 4'hF, 4'h0, 0, got);
        req(32'h400, 4'hF, 4'h0, 0, got);
        req(32'h500, 4'hF, 4'h0, 0, got);
        chk(got == 32'h5000_0500, "evict_fill_data", got, 32'h5000_0500);
        chk(last_wr_addr == 32'h100, "evict_wb_addr", last_wr_addr, 32'h100);
        chk(last_wr_data[31:0] == 32'hDEAD_ABEF, "evict_wb_word0", last_wr_data[31:0], 32'hDEAD_ABEF);
        chk(last_rd_addr == 32'h500, "evict_fetch_addr", last_rd_addr, 32'h500);

        req(32'h208, 4'h0, 4'hF, 32'h1234_5678, got);
        req(32'h600, 4'hF, 4'h0, 0, got);
        chk(last_wr_addr == 32'h200, "rr_wb_addr", last_wr_addr, 32'h200);
        chk(last_wr_data[95:64] == 32'h1234_5678, "rr_wb_word2", last_wr_data[95:64], 32'h1234_5678);
        req(32'h208, 4'hF, 4'h0, 0, got);
        chk(got == 32'h1234_5678, "wb_refetch", got, 32'h1234_5678);

        chk_en = 0;
        mem_en = 0;
        @(posedge clk);
        #1;
        ufp_addr = 32'h700; ufp_rmask = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!dfp_read && n < 20);
        chk(dfp_read, "rst_fetch_seen", dfp_read, 1);
        @(posedge clk);
        #1;
        rst = 1; ufp_rmask = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk(dfp_read == 0 && dfp_write == 0, "rst_abandon_dfp", {dfp_read, dfp_write}, 0);
        chk(ufp_resp == 0, "rst_abandon_resp", ufp_resp, 0);
        @(posedge clk);
        #1;
        stray_resp = 1;
        @(posedge clk);
        #1;
        stray_resp = 0;
        @(negedge clk);
        chk(!ufp_resp && !dfp_read && !dfp_write, "stray_ignored", {ufp_resp, dfp_read, dfp_write}, 0);
        for (int i = 0; i < NL; i++) begin s_v[i] = 0; s_d[i] = 0; end
        rr = 0; m_hit = 0; m_miss = 0;
        arch.delete();
        foreach (mem[k]) arch[k] = mem[k];
        mem_en = 1;
        chk_en = 1;

        req(32'h100, 4'hF, 4'h0, 0, got);
        chk(got == 32'hDEAD_ABEF, "post_reset_read", got, 32'hDEAD_ABEF);
        chk(last_rd_addr == 32'h100, "post_reset_miss", last_rd_addr, 32'h100);
        req(32'h100, 4'hF, 4'h0, 0, got);
        req(32'h104, 4'hF, 4'h0, 0, got);
        req(32'h108, 4'hF, 4'h0, 0, got);
        chk(got == 32'h5000_0108, "post_reset_hit", got, 32'h5000_0108);
`ifdef DLINE_PERF_CNT_EN
        chk(hit_count == 3, "hit_count", hit_count, 3);
        chk(miss_count == 1, "miss_count", miss_count, 1);
        chk(hit_count == m_hit && miss_count == m_miss, "perf_vs_model", {hit_count, miss_count}, {m_hit, m_miss});
`endif
        repeat (2) @(posedge clk);
        chk_en = 0;
        $display("model tally since reset: hits=%0d misses=%0d", m_hit, m_miss);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dline_responder.md
# dline_responder

Data-side line buffer that answers the `ufp_*` word-request protocol driven by the data prefetcher, sitting between the prefetcher and main memory. It holds a small fully-associative set of 32-byte lines and returns one response per request. Misses are serviced through a line-wide `dfp_*` port. That port's `dfp_addr`/`dfp_read` pair is the observation point the prefetcher uses for miss detection and stride training.

## Interface
- NUM_LINES, 4, line entries; power of two, 2..16
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ufp_addr  in  32  byte address; bits [1:0] ignored, word = addr[4:2]
- ufp_rmask  in  4  byte read mask; nonzero = read request
- ufp_wmask  in  4  byte write mask; nonzero = write request (wins if both nonzero)
- ufp_wdata  in  32  write data, byte lanes per ufp_wmask
- ufp_rdata  out  32  read data; valid only with ufp_resp, else 0
- ufp_resp  out  1  one-cycle completion pulse
- dfp_addr  out  32  line address, bits [4:0] = 0
- dfp_read  out  1  line fetch request, held until dfp_resp
- dfp_write  out  1  line writeback request, held until dfp_resp
- dfp_wdata  out  256  writeback line data
- dfp_rdata  in  256  fetched line data, valid with dfp_resp
- dfp_resp  in  1  one-cycle completion from memory

## Operation
- Per entry: valid, dirty, tag = addr[31:5], 256-bit data. Round-robin victim pointer, log2(NUM_LINES) bits.
- IDLE: if rmask|wmask is nonzero, register addr, masks and wdata, then go to LOOKUP. Requests are sampled only in IDLE.
- LOOKUP compares the registered tag against all valid entries.
  - Hit, read: ufp_resp=1. ufp_rdata = selected word with unmasked bytes zeroed. Go to IDLE.
  - Hit, write: merge masked bytes, set dirty, ufp_resp=1, ufp_rdata=0. Go to IDLE.
  - Miss: choose a victim. Prefer the lowest-index invalid entry; otherwise use the round-robin pointer.
  - Miss with a valid, dirty victim: go to WRITEBACK. Otherwise go to FETCH.
- WRITEBACK: dfp_write=1, dfp_addr = {victim tag, 5'b0}, dfp_wdata = victim data. On dfp_resp, clear dirty and go to FETCH.
- FETCH: dfp_read=1, dfp_addr = {req tag, 5'b0}. On dfp_resp:
  - install dfp_rdata with valid=1, dirty=0;
  - advance the round-robin pointer only if the victim was a replacement;
  - go to LOOKUP, which now hits.
- Write-allocate, write-back. No dirty data is lost except on reset.
- Requester holds ufp_* stable until ufp_resp. The block does not re-check ufp_* after sampling.
- Reset clears all valid/dirty bits and the pointer, and forces state to IDLE.
- All outputs are 0 in reset and in IDLE.
- Reset mid-WRITEBACK or mid-FETCH abandons the transfer. dfp_read/dfp_write are 0 from the next cycle. A stray dfp_resp received in IDLE or LOOKUP is ignored.
- dfp_read and dfp_write are never asserted together.

## Timing
- Request present in cycle 0 (IDLE): hit gives ufp_resp in cycle 1. The next request is sampled in cycle 2 at the earliest.
- Clean miss: dfp_read rises in cycle 2. If dfp_resp arrives in cycle k, ufp_resp comes in cycle k+2.
- Dirty miss: dfp_write rises in cycle 2. dfp_read rises the cycle after the write's dfp_resp.
- dfp_addr and dfp_wdata are stable for the entire time dfp_read or dfp_write is high.
- ufp_resp is never high in two consecutive cycles.

## Configuration
- DLINE_PERF_CNT_EN defined: adds output ports hit_count and miss_count, each 32 bits.
  - hit_count increments on first-pass LOOKUP hits; miss_count increments on each LOOKUP miss.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- DLINE_PERF_CNT_EN undefined: neither port nor counter exists. Functional behaviour is identical.

## Test plan
- Cold read: rst, then rmask=4'hF, addr=0x100. Expect dfp_read with dfp_addr=0x100. Return a line with word 0 = 0xDEADBEEF; expect ufp_resp with rdata=0xDEADBEEF two cycles after dfp_resp.
- Hit latency: repeat read of 0x104 after the fill. Expect ufp_resp exactly 1 cycle after the request, with no dfp activity.
- Byte write merge: wmask=4'b0010, wdata=0x0000AB00 to 0x100, then read 0x100. Expect 0xDEADABEF.
- Dirty eviction (NUM_LINES=4): write 0x100, then read 0x200, 0x300, 0x400, 0x500.
  - Expect dfp_write with dfp_addr=0x100 and the merged data, followed by dfp_read 0x500.
- Reset mid-fetch: assert rst while dfp_read is high. Expect dfp_read=0 and ufp_resp=0 next cycle. A late dfp_resp is ignored, and reading 0x100 afterwards misses.
- DLINE_PERF_CNT_EN: run the cold read plus 3 hits. Expect miss_count=1 and hit_count=3.
